pmp_csr_regfile: RTL
====================

// Module: pmp_csr_regfile
// PURPOSE
// - Responder end of the PMP CSR port: executes CSRRW/S/C(I) on pmpcfg0-3 (0x3A0-0x3A3) and pmpaddr0-15 (0x3B0-0x3BF).
// - Returns old value, response code and rvalid; holds the response until the bus acknowledges with pmp_rrsp.
// - Exports the architectural cfg/addr state to the PMP checker.
// PARAMETERS
// - ADDR_WIDTH   32  CSR address width; only [11:0] decoded; must equal REG_WIDTH.
// - REG_WIDTH    32  CSR data width (RV32).
// - PMP_ENTRIES  16  entries implemented; multiple of 4, 4..16.
// PORTS
// - clk            in   1                      clock
// - rst            in   1                      synchronous, active-high reset
// - pmp_reg_en     in   1                      request strobe, 1 cycle; accepted only in IDLE
// - pmp_reg_op     in   2                      [1] read, [0] write (write suppressed when 0)
// - pmp_funct3     in   3                      001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
// - pmp_csr_imm    in   5                      zimm, zero-extended for *I ops
// - pmp_rs1_val    in   REG_WIDTH              rs1 operand
// - pmp_addr       in   ADDR_WIDTH             CSR address
// - pmp_rrsp       in   1                      response accepted by bus
// - pmp_rdata      out  REG_WIDTH              old CSR value
// - pmp_rvalid     out  1                      response valid
// - pmp_act_rsp    out  3                      [2] exception, [1:0] cause
// - pmp_busy       out  1                      high in EXEC/RSP
// - pmp_cfg_flat   out  8*PMP_ENTRIES          entry i at [8i+7:8i]
// - pmp_addr_flat  out  REG_WIDTH*PMP_ENTRIES  entry i at [REG_WIDTH*i +: REG_WIDTH]
// BEHAVIOUR
// - Reset: every output 0, all cfg/addr registers 0, FSM in IDLE; reset mid-request drops it with no response.
// - FSM: IDLE -(reg_en)-> EXEC -> RSP -(rrsp)-> IDLE.
//   - Cycle N: reg_en seen in IDLE, inputs latched.
//   - Edge N+1: write committed, response registered.
//   - rvalid high from N+2 until the cycle rrsp is sampled high, inclusive; IDLE on the next cycle.
//   - Back-to-back rate is 1 request per 3 cycles.
// - pmp_reg_en while busy is ignored, with no side effects and no response.
// - rdata/act_rsp are stable while rvalid is high. rrsp sampled outside RSP is ignored.
// - Operand: funct3[2] ? {27'b0,imm} : rs1_val. New value:
//   - RW: operand
//   - RS: old | operand
//   - RC: old & ~operand
// - Write happens only if reg_op[0]=1 and act_rsp[2]=0. rdata is always the old value; it is 0 on exception.
// - act_rsp codes:
//   - 3'b000 OK
//   - 3'b101 illegal funct3 (000 or 100)
//   - 3'b110 addr outside 0x3A0-0x3EF
//   - 3'b111 locked write (macro only, see CONFIGURATION)
// - Illegal funct3 takes priority over bad address.
// - In range but unimplemented: 0x3A4-0x3AF, 0x3C0-0x3EF, and entries >= PMP_ENTRIES. These read 0, ignore writes, respond OK.
// - WARL rules for a cfg byte (L[7], A[4:3], X[2], W[1], R[0]):
//   - Bits [6:5] are written as 0.
//   - A written byte with W=1 and R=0 keeps its previous value entirely.
//   - A byte with L=1 ignores writes.
//   - Other bytes of the same pmpcfg word still update independently.
// - pmpaddr[i] ignores writes if cfg[i].L=1, or if cfg[i+1].L=1 and cfg[i+1].A=TOR(01).
// - Lock decisions use pre-write state, so a write that sets L takes effect with that same write.
// - L is cleared only by rst.
// - Flat outputs are driven directly from the registers and update the cycle after commit.
// CONFIGURATION
// - PMP_CSR_LOCK_ERR_EN defined:
//   - A write request where every targeted byte/entry is locked responds 3'b111 and writes nothing.
//   - Partial-lock cfg writes update the unlocked bytes and respond OK.
// - PMP_CSR_LOCK_ERR_EN undefined: locked writes are silently dropped and respond 3'b000.
// TESTING
// - Reset, then read 0x3B0 -> rvalid at N+2, rdata=0, act_rsp=000; rvalid held until rrsp.
// - RW 0x3B3 rs1=0x1234_5678, then RS imm=0x3, then RC rs1=0x8 -> reads return 0x0, 0x1234_5678, 0x1234_567B; final 0x1234_5673.
// - RW 0x3A0 rs1=0x0000_8F02:
//   - byte0 W-only kept at 0, byte1 = 0x8F & 0x9F = 0x8F (L=1).
//   - Later RW 0x3A0 rs1=0x0 -> byte1 stays 0x8F.
//   - RW 0x3B1 is dropped; 0x3B0 is dropped if cfg1.A=TOR.
// - funct3=100 -> 3'b101; addr 0x300 -> 3'b110; addr 0x3C5 -> OK, rdata 0; no state change in all three.
// - Hold rrsp=0 for 10 cycles with a second reg_en during RSP -> one response only; stall release -> IDLE; rst during EXEC -> no rvalid.
// - With PMP_CSR_LOCK_ERR_EN: write to locked pmpaddr1 -> 3'b111, value unchanged.

Source files
------------

// File: rtl/pmp_csr_regfile.sv
// PMP CSR responder: CSRRW/S/C(I) on pmpcfg0-3 and pmpaddr0-15 with WARL and lock rules.
// Optional macro PMP_CSR_LOCK_ERR_EN: fully locked write targets respond 3'b111.
module pmp_csr_regfile #(
  parameter int ADDR_WIDTH  = 32,
  parameter int REG_WIDTH   = 32,
  parameter int PMP_ENTRIES = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             pmp_reg_en,
  input  logic [1:0]                       pmp_reg_op,
  input  logic [2:0]                       pmp_funct3,
  input  logic [4:0]                       pmp_csr_imm,
  input  logic [REG_WIDTH-1:0]             pmp_rs1_val,
  input  logic [ADDR_WIDTH-1:0]            pmp_addr,
  input  logic                             pmp_rrsp,
  output logic [REG_WIDTH-1:0]             pmp_rdata,
  output logic                             pmp_rvalid,
  output logic [2:0]                       pmp_act_rsp,
  output logic                             pmp_busy,
  output logic [8*PMP_ENTRIES-1:0]         pmp_cfg_flat,
  output logic [REG_WIDTH*PMP_ENTRIES-1:0] pmp_addr_flat
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RSP  = 2'd2;
  localparam int NCFG = PMP_ENTRIES / 4;

  logic [1:0]           state_q, state_d;
  logic                 req_wr_q;
  logic [2:0]           req_f3_q;
  logic [4:0]           req_imm_q;
  logic [REG_WIDTH-1:0] req_rs1_q;
  logic [11:0]          req_csr_q;
  logic                 rvalid_q;
  logic [REG_WIDTH-1:0] rdata_q;
  logic [2:0]           rsp_q;
  logic [7:0]           cfg_q  [PMP_ENTRIES];
  logic [7:0]           cfg_d  [PMP_ENTRIES];
  logic [REG_WIDTH-1:0] addr_q [PMP_ENTRIES];
  logic [REG_WIDTH-1:0] addr_d [PMP_ENTRIES];

  logic                   cfg_sel, addr_sel, in_range, tgt_locked, wr_en;
  logic [PMP_ENTRIES-1:0] addr_lock;
  logic [7:0]             nxt_cfg, wbyte;
  logic [REG_WIDTH-1:0]   old_val, operand, new_val;
  logic [2:0]             rsp_code;
  logic                   unused_bits;

  assign unused_bits = ^{pmp_reg_op[1], pmp_addr[ADDR_WIDTH-1:12]};

  // An entry's address is frozen by its own L bit or by a locked TOR entry directly above it.
  always_comb begin
    nxt_cfg   = 8'h00;
    addr_lock = '0;
    for (int i = 0; i < PMP_ENTRIES; i++) begin
      nxt_cfg      = (i == PMP_ENTRIES - 1) ? 8'h00 : cfg_q[(i + 1) % PMP_ENTRIES];
      addr_lock[i] = cfg_q[i][7] | (nxt_cfg[7] & (nxt_cfg[4:3] == 2'b01));
    end
  end

  always_comb begin
    cfg_sel    = (req_csr_q[11:2] == 10'h0E8) && (int'(req_csr_q[1:0]) < NCFG);
    addr_sel   = (req_csr_q[11:4] == 8'h3B) && (int'(req_csr_q[3:0]) < PMP_ENTRIES);
    in_range   = (req_csr_q >= 12'h3A0) && (req_csr_q <= 12'h3EF);
    old_val    = '0;
    tgt_locked = cfg_sel | addr_sel;
    for (int i = 0; i < PMP_ENTRIES; i++) begin
      if (cfg_sel && ((i / 4) == int'(req_csr_q[1:0]))) begin
        old_val[8*(i%4) +: 8] = cfg_q[i];
        tgt_locked            = tgt_locked & cfg_q[i][7];
      end
      if (addr_sel && (i == int'(req_csr_q[3:0]))) begin
        old_val    = addr_q[i];
        tgt_locked = tgt_locked & addr_lock[i];
      end
    end
  end

  always_comb begin
    if (req_f3_q[1:0] == 2'b00) begin
      rsp_code = 3'b101;
    end else if (!in_range) begin
      rsp_code = 3'b110;
`ifdef PMP_CSR_LOCK_ERR_EN
    end else if (req_wr_q && tgt_locked) begin
      rsp_code = 3'b111;
`endif
    end else begin
      rsp_code = 3'b000;
    end
  end

`ifndef PMP_CSR_LOCK_ERR_EN
  logic unused_lock;
  assign unused_lock = tgt_locked;
`endif

  always_comb begin
    operand = req_f3_q[2] ? REG_WIDTH'(req_imm_q) : req_rs1_q;
    case (req_f3_q[1:0])
      2'b01:   new_val = operand;
      2'b10:   new_val = old_val | operand;
      2'b11:   new_val = old_val & ~operand;
      default: new_val = old_val;
    endcase
    wr_en = (state_q == S_EXEC) && req_wr_q && !rsp_code[2];
  end

  // Each cfg byte commits independently; W=1/R=0 encodings leave the byte untouched.
  always_comb begin
    wbyte = 8'h00;
    for (int i = 0; i < PMP_ENTRIES; i++) begin
      cfg_d[i]  = cfg_q[i];
      addr_d[i] = addr_q[i];
      wbyte     = new_val[8*(i%4) +: 8];
      if (wr_en && cfg_sel && ((i / 4) == int'(req_csr_q[1:0])) && !cfg_q[i][7] &&
          !(wbyte[1] && !wbyte[0]))
        cfg_d[i] = wbyte & 8'h9F;
      if (wr_en && addr_sel && (i == int'(req_csr_q[3:0])) && !addr_lock[i])
        addr_d[i] = new_val;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pmp_reg_en) state_d = S_EXEC;
      S_EXEC:  state_d = S_RSP;
      S_RSP:   if (pmp_rrsp) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      req_wr_q  <= 1'b0;
      req_f3_q  <= 3'b000;
      req_imm_q <= 5'd0;
      req_rs1_q <= '0;
      req_csr_q <= 12'h000;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rsp_q     <= 3'b000;
      for (int i = 0; i < PMP_ENTRIES; i++) begin
        cfg_q[i]  <= 8'h00;
        addr_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      addr_q  <= addr_d;
      if (state_q == S_IDLE && pmp_reg_en) begin
        req_wr_q  <= pmp_reg_op[0];
        req_f3_q  <= pmp_funct3;
        req_imm_q <= pmp_csr_imm;
        req_rs1_q <= pmp_rs1_val;
        req_csr_q <= pmp_addr[11:0];
      end
      if (state_q == S_EXEC) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rsp_code[2] ? '0 : old_val;
        rsp_q    <= rsp_code;
      end else if (state_q == S_RSP && pmp_rrsp) begin
        rvalid_q <= 1'b0;
        rdata_q  <= '0;
        rsp_q    <= 3'b000;
      end
    end
  end

  assign pmp_rvalid  = rvalid_q;
  assign pmp_rdata   = rdata_q;
  assign pmp_act_rsp = rsp_q;
  assign pmp_busy    = (state_q == S_EXEC) || (state_q == S_RSP);

  for (genvar gi = 0; gi < PMP_ENTRIES; gi++) begin : g_flat
    assign pmp_cfg_flat[8*gi +: 8]                = cfg_q[gi];
    assign pmp_addr_flat[REG_WIDTH*gi +: REG_WIDTH] = addr_q[gi];
  end

endmodule
